ps2_rx_fifo: RTL
================

# ps2_rx_fifo

Parametrised PS/2 keyboard receiver that succeeds the single-register scan-code capture block. Runs entirely in the system clock domain and synchronises and glitch-filters the PS/2 clock and data pins. Checks every 11-bit frame, folds E0/F0 prefix bytes into flags, and buffers decoded key events in a FIFO drained by a valid/ready consumer. Sits between the keyboard pins and the game/control logic.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive equal samples required before a filtered pin level changes (≥2).
- TIMEOUT_CYC, 50000: clk cycles without a PS/2 falling edge before an in-progress frame is aborted.
- FIFO_DEPTH, 8: event FIFO entries (power of two, ≥2).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- PS2_clk  in  1  raw PS/2 clock pin (asynchronous).
- PS2_data  in  1  raw PS/2 data pin (asynchronous).
- key_valid  out  1  FIFO head holds an event.
- key_ready  in  1  consumer accepts head when key_valid & key_ready.
- key_code  out  8  scan code of head event.
- key_ext  out  1  head event was preceded by E0.
- key_break  out  1  head event was preceded by F0 (key release).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  one-cycle pulse: event dropped because FIFO full.
- frame_err  out  1  one-cycle pulse: bad start, parity, stop or timeout.

## Operation
- Each pin: 2-FF synchroniser, then filter; filtered level changes only after FILTER_LEN identical synchronised samples. Filtered levels reset to 1.
- Falling edge of filtered clock = sample strobe; data sampled is filtered data at that cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with data=0 -> DATA, bit count 0; strobe with data=1 -> stay IDLE, frame_err.
  - DATA: shift 8 bits LSB first; after 8th -> PARITY.
  - PARITY: record bit -> STOP.
  - STOP: data=1 and parity OK -> byte accepted; otherwise frame_err. Always -> IDLE.
- Timeout counter clears on every strobe and in IDLE; reaching TIMEOUT_CYC outside IDLE -> IDLE, frame_err, partial byte discarded.
- Decoder on accepted byte: E0 sets ext flag, F0 sets brk flag, neither pushed; any other byte pushes {ext,brk,code} and clears both flags. frame_err clears both flags.
- FIFO: show-ahead; key_code/key_ext/key_break reflect head while key_valid, 0 when empty.
- Push when full and no pop: event dropped, overflow pulse, contents unchanged. Push and pop same cycle when full: both occur, count unchanged. Pop when empty: ignored.
- Reset mid-frame: FSM IDLE, flags cleared, FIFO emptied, timeout cleared; all outputs 0.

## Timing
- Pin-to-strobe latency: 2 + FILTER_LEN cycles.
- Stop-bit strobe in cycle N -> push in N+1 -> key_valid, fifo_count updated in N+2.
- frame_err: cycle after the offending strobe or timeout expiry. overflow: in the push cycle.
- Pop in cycle N: next head/fifo_count visible in N+1.
- Consumer may hold key_ready high continuously: one event per cycle sustained.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity enforced; mismatch -> frame_err, byte discarded.
- Undefined: parity bit sampled but ignored; only start/stop/timeout raise frame_err.

## Structure
- Package ps2_pkg: FSM state enum, E0/F0 prefix constants, frame bit count (11), event struct {ext, brk, code[7:0]}.
- Sub-module ps2_filter (synchroniser + stability filter), instantiated once per pin; FIFO inline.

## Test plan
- Reset, send frame 0x1C (odd parity bit 0, stop 1), key_ready=1 -> one event code=0x1C, ext=0, brk=0; fifo_count returns 0.
- Send F0,1C then E0,F0,75 -> events {0x1C,brk=1} then {0x75,ext=1,brk=1}; no events for prefixes.
- Bad parity on 0x1C with PS2_PARITY_CHECK_EN -> frame_err pulse, no event; without macro -> event 0x1C.
- Stop clock after 5 bits for > TIMEOUT_CYC -> frame_err, FSM IDLE; following good frame 0x2A decoded correctly.
- key_ready=0, send FIFO_DEPTH+1 bytes -> fifo_count=FIFO_DEPTH, one overflow pulse, drain returns first FIFO_DEPTH codes in order.
- 1-cycle glitches (< FILTER_LEN) on PS2_clk during frame 0x1C -> no extra strobes, event 0x1C; assert rst mid-frame -> all outputs 0, FIFO empty.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver slice.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0]  PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0]  PS2_PFX_BRK    = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 11;
  // start, parity and stop surround the payload
  localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a stability filter for one PS/2 pin.
// The filtered level only moves after FILTER_LEN consecutive equal samples.
module ps2_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level
);

  localparam int unsigned CW = $clog2(FILTER_LEN);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Synchroniser shift and run-length count of samples disagreeing with level
  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pin state registers; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin filtering, frame checking, E0/F0 prefix folding
// and a show-ahead event FIFO with a valid/ready consumer port.
// Optional feature macro: PS2_PARITY_CHECK_EN (enforce odd parity).
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PS2_clk,
  input  logic                          PS2_data,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic clk_lvl, data_lvl, strobe, parity_ok;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .pin(PS2_clk), .level(clk_lvl)
  );
  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .rst(rst), .pin(PS2_data), .level(data_lvl)
  );

  ps2_state_e    state_q, state_d;
  logic          clk_prev_q, clk_prev_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          acc_valid_q, acc_valid_d;
  logic [7:0]    acc_byte_q, acc_byte_d;
  logic          err_q, err_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  key_event_t    mem_q [FIFO_DEPTH];
  key_event_t    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, full, wr;
  key_event_t    ev, head;

  assign strobe    = clk_prev_q & ~clk_lvl;
  assign parity_ok = !PAR_EN || (^{shift_q, parity_q});

  // Frame FSM: next state, shift register and inactivity timeout
  always_comb begin
    clk_prev_d  = clk_lvl;
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    acc_valid_d = 1'b0;
    acc_byte_d  = acc_byte_q;
    err_d       = 1'b0;
    tmo_d       = '0;
    if (state_q != ST_IDLE && !strobe) tmo_d = tmo_q + 1'b1;
    if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (data_lvl) begin
            err_d = 1'b1;
          end else begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d  = {data_lvl, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_lvl;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_lvl && parity_ok) begin
            acc_valid_d = 1'b1;
            acc_byte_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  // Prefix folding and FIFO bookkeeping
  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    push    = 1'b0;
    ev      = '{ext: ext_q, brk: brk_q, code: acc_byte_q};
    if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (acc_valid_q) begin
      if (acc_byte_q == PS2_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (acc_byte_q == PS2_PFX_BRK) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    key_valid = (count_q != '0);
    pop       = key_valid & key_ready;
    full      = (count_q == CW'(FIFO_DEPTH));
    // a pop frees the slot the same cycle, so a full FIFO still accepts
    wr        = push & (~full | pop);
    overflow  = push & full & ~pop;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (wr) begin
      mem_d[wptr_q] = ev;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    count_d = count_q + CW'(wr) - CW'(pop);
    head    = key_valid ? mem_q[rptr_q] : '0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      acc_valid_q <= 1'b0;
      acc_byte_q  <= '0;
      err_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      acc_valid_q <= acc_valid_d;
      acc_byte_q  <= acc_byte_d;
      err_q       <= err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  assign key_code   = head.code;
  assign key_ext    = head.ext;
  assign key_break  = head.brk;
  assign fifo_count = count_q;
  assign frame_err  = err_q;

endmodule
